// File: rtl/glift_pkg.sv
// Shared types and the GLIFT mux-taint helper for the max/min tracker.
package glift_pkg;

    localparam int DW_DEFAULT = 4;

    typedef logic [DW_DEFAULT-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Taint of sel ? a : b: the chosen operand's taint, plus every bit where the
    // operands differ when the select itself is tainted.
    function automatic word_t taint_mux(
        input logic  sel,
        input logic  sel_t,
        input word_t a,
        input word_t b,
        input word_t a_t,
        input word_t b_t
    );
        return (sel ? a_t : b_t) | ({DW_DEFAULT{sel_t}} & (a ^ b));
    endfunction

endpackage

// File: rtl/glift_cmp_select.sv
// Combinational compare-and-select with GLIFT taint; FIND_MIN picks '<' instead of '>'.
module glift_cmp_select
    import glift_pkg::*;
#(
    parameter bit FIND_MIN = 1'b0
) (
    input  word_t cur,
    input  word_t cur_t,
    input  word_t smp,
    input  word_t smp_t,
    output word_t nxt,
    output word_t nxt_t,
    output logic  sel_t
);

    logic take;

    // Ties never take the new sample, so equal values keep the stored taint.
    assign take  = FIND_MIN ? (smp < cur) : (smp > cur);
    assign sel_t = |(smp_t | cur_t);
    assign nxt   = take ? smp : cur;
    assign nxt_t = taint_mux(take, sel_t, smp, cur, smp_t, cur_t);

endmodule

// File: rtl/glift_max_tracker.sv
// Windowed running maximum with GLIFT taint; one result per N_SAMPLES accepted samples.
// Define GLIFT_TRACK_MIN_EN to also track the running minimum (out_min/out_min_t).
module glift_max_tracker
    import glift_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,  // must equal the package word width
    parameter int N_SAMPLES = 4,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_taint,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_max_t,
    output logic          out_sel_t,
`ifdef GLIFT_TRACK_MIN_EN
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_min_t,
`endif
    output logic [CW-1:0] out_count
);

    state_e        state;
    logic [DW-1:0] max_q, max_t_q;
    logic [DW-1:0] max_nxt, max_t_nxt;
    logic          max_sel_t;
    logic          sel_t_acc;
    logic          sel_t_all;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;

    // NOTE: in_ready depends only on state, so a result handshake never admits a sample in the same cycle.
    assign in_ready = (state != DONE);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt + CW'(1)) == CW'(N_SAMPLES);

    glift_cmp_select #(.FIND_MIN(1'b0)) u_max_sel (
        .cur   (max_q),
        .cur_t (max_t_q),
        .smp   (in_data),
        .smp_t (in_taint),
        .nxt   (max_nxt),
        .nxt_t (max_t_nxt),
        .sel_t (max_sel_t)
    );

`ifdef GLIFT_TRACK_MIN_EN
    logic [DW-1:0] min_q, min_t_q;
    logic [DW-1:0] min_nxt, min_t_nxt;
    logic          min_sel_t;

    glift_cmp_select #(.FIND_MIN(1'b1)) u_min_sel (
        .cur   (min_q),
        .cur_t (min_t_q),
        .smp   (in_data),
        .smp_t (in_taint),
        .nxt   (min_nxt),
        .nxt_t (min_t_nxt),
        .sel_t (min_sel_t)
    );

    assign sel_t_all = max_sel_t | min_sel_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q     <= '0;
            min_t_q   <= '0;
            out_min   <= '0;
            out_min_t <= '0;
        end else if (accept && state == IDLE) begin
            min_q   <= in_data;
            min_t_q <= in_taint;
            if (N_SAMPLES == 1) begin
                out_min   <= in_data;
                out_min_t <= in_taint;
            end
        end else if (accept && state == ACCUM) begin
            min_q   <= min_nxt;
            min_t_q <= min_t_nxt;
            if (last) begin
                out_min   <= min_nxt;
                out_min_t <= min_t_nxt;
            end
        end
    end
`else
    assign sel_t_all = max_sel_t;
`endif

    // NOTE: every state register resets asynchronously, so a reset mid-window drops the partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            max_q     <= '0;
            max_t_q   <= '0;
            sel_t_acc <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_max_t <= '0;
            out_sel_t <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    max_q     <= in_data;
                    max_t_q   <= in_taint;
                    sel_t_acc <= 1'b0;
                    cnt       <= CW'(1);
                    if (N_SAMPLES == 1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_max   <= in_data;
                        out_max_t <= in_taint;
                        out_sel_t <= 1'b0;
                        out_count <= CW'(N_SAMPLES);
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    max_q     <= max_nxt;
                    max_t_q   <= max_t_nxt;
                    sel_t_acc <= sel_t_acc | sel_t_all;
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_max   <= max_nxt;
                        out_max_t <= max_t_nxt;
                        out_sel_t <= sel_t_acc | sel_t_all;
                        out_count <= CW'(N_SAMPLES);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glift_max_tracker.sv
// Scoreboard bench for glift_max_tracker: directed windows, expected results queued, monitor compares.
module tb_glift_max_tracker;

    localparam int DW = 4;
    localparam int CW = 8;
    localparam int NS = 4;

    typedef struct {
        logic [DW-1:0] mx;
        logic [DW-1:0] mx_t;
        logic          sel_t;
        logic [DW-1:0] mn;
        logic [DW-1:0] mn_t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_taint;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_max;
    logic [DW-1:0] out_max_t;
    logic          out_sel_t;
    logic [CW-1:0] out_count;
`ifdef GLIFT_TRACK_MIN_EN
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_min_t;
`endif

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    glift_max_tracker #(.DW(DW), .N_SAMPLES(NS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_taint  (in_taint),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_max_t (out_max_t),
        .out_sel_t (out_sel_t),
`ifdef GLIFT_TRACK_MIN_EN
        .out_min   (out_min),
        .out_min_t (out_min_t),
`endif
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] mx, input logic [DW-1:0] mx_t, input logic sel_t,
                            input logic [DW-1:0] mn, input logic [DW-1:0] mn_t);
        exp_t e;
        e.mx = mx; e.mx_t = mx_t; e.sel_t = sel_t; e.mn = mn; e.mn_t = mn_t;
        sb.push_back(e);
    endtask

    // Presents one sample and returns 1ns after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] t);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_taint = t;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_max", out_max, e.mx);
                    check("out_max_t", out_max_t, e.mx_t);
                    check("out_sel_t", out_sel_t, e.sel_t);
                    check("out_count", out_count, NS);
`ifdef GLIFT_TRACK_MIN_EN
                    check("out_min", out_min, e.mn);
                    check("out_min_t", out_min_t, e.mn_t);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_taint = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_max", out_max, 0);
        check("rst_out_max_t", out_max_t, 0);
        check("rst_out_count", out_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Untainted window, plus latency of out_valid.
        push_exp(4'd9, 4'b0000, 1'b0, 4'd2, 4'b0000);
        send(4'd3, 4'b0000);
        send(4'd9, 4'b0000);
        send(4'd2, 4'b0000);
        check("t1_valid_early", out_valid, 0);
        send(4'd7, 4'b0000);
        check("t1_latency", out_valid, 1);
        settle();

        // Tainted select: 5^12 differs in bits 3 and 0.
        push_exp(4'd12, 4'b1001, 1'b1, 4'd5, 4'b1001);
        send(4'd5, 4'b0000);
        send(4'd12, 4'b0001);
        send(4'd12, 4'b0000);
        send(4'd12, 4'b0000);
        settle();

        // Backpressure: result held, pending sample not consumed.
        out_ready = 1'b0;
        push_exp(4'd4, 4'b0000, 1'b0, 4'd1, 4'b0000);
        send(4'd1, 4'b0000);
        send(4'd2, 4'b0000);
        send(4'd3, 4'b0000);
        send(4'd4, 4'b0000);
        in_valid = 1'b1;
        in_data  = 4'd15;
        in_taint = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_max", out_max, 4);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_exp(4'd15, 4'b0000, 1'b0, 4'd1, 4'b0000);
        send(4'd15, 4'b0000);
        send(4'd1, 4'b0000);
        send(4'd1, 4'b0000);
        send(4'd1, 4'b0000);
        settle();

        // Equal values keep stored taint; tainted select with no differing bits.
        push_exp(4'd6, 4'b0000, 1'b1, 4'd6, 4'b0000);
        send(4'd6, 4'b0000);
        send(4'd6, 4'b0110);
        send(4'd6, 4'b0000);
        send(4'd6, 4'b0000);
        settle();

        // Reset mid-window: partial window dropped, outputs clear asynchronously.
        send(4'd9, 4'b1111);
        send(4'd3, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_max", out_max, 0);
        check("mid_rst_out_sel_t", out_sel_t, 0);
        check("mid_rst_out_count", out_count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        push_exp(4'd4, 4'b0000, 1'b0, 4'd1, 4'b0000);
        send(4'd1, 4'b0000);
        send(4'd2, 4'b0000);
        send(4'd3, 4'b0000);
        send(4'd4, 4'b0000);
        settle();

        // Mixed order for max and min.
        push_exp(4'd15, 4'b0000, 1'b0, 4'd1, 4'b0000);
        send(4'd8, 4'b0000);
        send(4'd1, 4'b0000);
        send(4'd15, 4'b0000);
        send(4'd4, 4'b0000);
        settle();

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/glift_max_tracker.md
Name: glift_max_tracker

Overview:
- Sequential stage that consumes a stream of 4-bit samples with per-bit GLIFT taint and keeps a running maximum and its taint.
- Issues one result (maximum, taint, and a taint flag on the greater decision) every N_SAMPLES accepted samples.
- Downstream of the team's GLIFT compare logic; its compare-select datapath uses GLIFT gate semantics.
- Feeds the taint-check/report stage through a valid/ready output.

Parameters:
- DW, 4, sample and taint width in bits.
- N_SAMPLES, 4, samples per window; legal range 1..255.
- CW, 8, sample-counter width; must hold N_SAMPLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DW  sample value.
- in_taint  in  DW  per-bit taint of in_data.
- out_valid  out  1  window result available.
- out_ready  in  1  consumer accepts the result.
- out_max  out  DW  window maximum.
- out_max_t  out  DW  per-bit taint of out_max.
- out_sel_t  out  1  set if any select decision in the window was tainted.
- out_count  out  CW  samples in the window (equals N_SAMPLES).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, max=0, max_t=0, sel_t_acc=0, cnt=0, out_valid=0, outputs all 0, in_ready=1.
- Accept rule: a sample is accepted on a rising edge where in_valid & in_ready.
- in_ready: 1 in IDLE and ACCUM, 0 in DONE.
- IDLE, on accept:
  - max <= in_data; max_t <= in_taint; sel_t_acc <= 0; cnt <= 1.
  - Go to DONE if N_SAMPLES==1, else ACCUM.
- ACCUM, on accept:
  - gt = (in_data > max), unsigned.
  - sel_t = |(in_taint | max_t), a conservative taint on the compare.
  - New max = gt ? in_data : max.
  - New taint bit i = (gt ? in_taint[i] : max_t[i]) | (sel_t & (in_data[i] ^ max[i])).
  - Equal values keep the stored max and select the stored taint.
  - sel_t_acc <= sel_t_acc | sel_t; cnt <= cnt+1.
  - When cnt+1 == N_SAMPLES, go to DONE.
- DONE:
  - out_valid=1; outputs are registered copies, stable while out_valid & !out_ready.
  - On out_ready: out_valid <= 0 and go to IDLE; in_ready rises the next cycle.
  - There is no bypass, so a sample arriving in the handshake cycle waits one cycle.
- Latency: out_valid asserts 1 cycle after the N_SAMPLES-th accept.
- Counter: cnt never wraps; it is cleared on entry to IDLE.
- Reset mid-window: the partial window is discarded and no output is produced.
- in_valid held while in_ready=0: the sample is not consumed; in_data/in_taint must stay stable (source obligation).

Optional Feature:
- Macro: GLIFT_TRACK_MIN_EN.
- Defined:
  - Adds outputs out_min (DW) and out_min_t (DW).
  - Running minimum uses the same rules with lt = (in_data < max... read as < min).
  - Its sel_t is computed from in_taint|min_t and also ORs into sel_t_acc.
  - Reset and handshake are identical to the max path.
- Undefined: ports absent, no min registers.

Decomposition:
- Package glift_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - DW default.
  - Helper function taint_mux(sel, sel_t, a, b, a_t, b_t), returning the DW-bit GLIFT mux taint.
- Sub-module glift_cmp_select:
  - Combinational: compare plus GLIFT select.
  - Outputs: new value, new taint, sel_t.
  - Instantiated once, or twice with GLIFT_TRACK_MIN_EN.
- Top: FSM, counter, registers.

Test Plan:
- Untainted window, N_SAMPLES=4, samples 3,9,2,7 all taint 0 -> out_max=9, out_max_t=0, out_sel_t=0, out_count=4, out_valid 1 cycle after 4th accept.
- Tainted select, samples 5 (t=0000), 12 (t=0001) -> sel_t=1 on 2nd compare; max=12; out_max_t = 0001 | (5^12 = 1001) = 1001; out_sel_t=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> in_ready=0, outputs stable, no sample consumed; out_ready=1 -> IDLE, next window starts clean with cnt=0.
- Equal values, samples 6,6 with taints 0000/0110 -> max stays the first sample with max_t=0000; sel_t=1 but value bits equal, so out_max_t=0000; out_sel_t=1.
- Reset mid-window: assert rst after 2 of 4 samples -> all outputs 0 immediately (async); the next 4 samples 1,2,3,4 give out_max=4.
- GLIFT_TRACK_MIN_EN defined, samples 8,1,15,4 -> out_max=15, out_min=1, taints 0.
